// File: rtl/instr_cache_ctrl_pkg.sv
// Shared types and derivations for the L0 instruction-cache control slice.
package instr_cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2,
    FLUSH     = 2'd3
  } ic_state_e;

  // A byte address splits into {tag, word-in-block, byte-in-word}.
  function automatic int tag_width(input int ram_width);
    return 30 - $clog2(ram_width / 32);
  endfunction

  function automatic int words_in_block(input int ram_width);
    return ram_width / 32;
  endfunction

  // Right-aligned tag moved to the top of a 32-bit block-aligned address.
  function automatic logic [31:0] block_addr(input logic [31:0] tag, input int tag_w);
    return tag << (32 - tag_w);
  endfunction

endpackage

// File: rtl/instr_cache_ctrl_if.sv
// Fetch-side and memory-side handshake bundle of the instruction-cache controller.
interface instr_cache_ctrl_if;
  // Both sides use request/grant: a transfer happens in the cycle where req
  // and gnt are high together; rvalid is a single-cycle data-valid strobe.
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;

  modport master (
    output instr_req_i, instr_addr_i, mem_gnt_i, mem_rvalid_i,
    input  instr_gnt_o, instr_rvalid_o, mem_req_o, mem_addr_o
  );

  modport slave (
    input  instr_req_i, instr_addr_i, mem_gnt_i, mem_rvalid_i,
    output instr_gnt_o, instr_rvalid_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/instr_cache_ctrl_rr_ptr.sv
// Round-robin line pointer: advances by one on inc_i and wraps naturally.
module instr_cache_rr_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_o <= '0;
    else if (inc_i) ptr_o <= ptr_o + 1'b1;
  end

endmodule

// File: rtl/instr_cache_ctrl.sv
// L0 instruction-cache control FSM: hit/miss sequencing, single-beat refill,
// soft flush, round-robin replacement and saturating hit/miss counters.
module instr_cache_ctrl
  import instr_cache_pkg::*;
#(
  parameter int LOG2_NUM_BLKS = 3,
  parameter int RAM_WIDTH     = 128,
  parameter int CNT_W         = 32,
  localparam int TAG_W        = tag_width(RAM_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  instr_cache_ctrl_if.slave        bus,
  input  logic                     flush_i,
  output logic                     flush_ack_o,
  output logic                     dp_search_o,
  output logic [31:0]              dp_addr_o,
  output logic                     dp_new_rvalid_o,
  output logic                     dp_new_rdata_o,
  output logic                     dp_soft_rst_o,
  output logic [TAG_W-1:0]         dp_tag_o,
  output logic [LOG2_NUM_BLKS-1:0] dp_rplc_idx_o,
  input  logic                     dp_miss_i,
  input  logic                     dp_data_ready_i
);

  ic_state_e               state_q;
  logic                    flush_pend_q;
  logic [31:0]             addr_q;
  logic [TAG_W-1:0]        tag_q;
  logic                    hit_q;
  logic [CNT_W-1:0]        hit_cnt;
  logic [CNT_W-1:0]        miss_cnt;
  logic [LOG2_NUM_BLKS-1:0] ptr;
  logic                    gnt;
  logic                    refill;

  // Grant and the IDLE address pass-through are input-driven, so they are
  // gated by rst to keep every output quiet while reset is held.
  assign gnt    = (state_q == IDLE) & bus.instr_req_i & ~flush_i & ~flush_pend_q & ~rst;
  assign refill = (state_q == MISS_WAIT) & bus.mem_rvalid_i;

  assign bus.instr_gnt_o    = gnt;
  assign dp_search_o        = gnt;
  assign dp_addr_o          = rst ? 32'd0 : ((state_q == IDLE) ? bus.instr_addr_i : addr_q);
  assign bus.instr_rvalid_o = (hit_q & dp_data_ready_i) | refill;
  assign dp_new_rdata_o     = refill;
  assign dp_new_rvalid_o    = refill;
  assign bus.mem_req_o      = (state_q == MISS_REQ);
  assign bus.mem_addr_o     = block_addr(32'(tag_q), TAG_W);
  assign flush_ack_o        = (state_q == FLUSH);
  assign dp_soft_rst_o      = (state_q == FLUSH);
  assign dp_tag_o           = tag_q;
  assign dp_rplc_idx_o      = ptr;

  instr_cache_rr_ptr #(.W(LOG2_NUM_BLKS)) u_rr_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (refill),
    .ptr_o (ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      addr_q       <= '0;
      tag_q        <= '0;
      hit_q        <= 1'b0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
    end else begin
      hit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush_i) begin
            state_q <= FLUSH;
          end else if (gnt) begin
            addr_q <= bus.instr_addr_i;
            if (dp_miss_i) begin
              tag_q   <= bus.instr_addr_i[31 -: TAG_W];
              state_q <= MISS_REQ;
              if (~&miss_cnt) miss_cnt <= miss_cnt + 1'b1;
            end else begin
              hit_q <= 1'b1;
              if (~&hit_cnt) hit_cnt <= hit_cnt + 1'b1;
            end
          end
        end
        MISS_REQ: begin
          if (flush_i) flush_pend_q <= 1'b1;
          if (bus.mem_gnt_i) state_q <= MISS_WAIT;
        end
        MISS_WAIT: begin
          if (flush_i) flush_pend_q <= 1'b1;
          // A flush arriving in the refill cycle itself is still honoured.
          if (bus.mem_rvalid_i) state_q <= (flush_pend_q | flush_i) ? FLUSH : IDLE;
        end
        FLUSH: begin
          flush_pend_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_cache_ctrl.sv
// Directed bench for instr_cache_ctrl with a small tag-store model standing in for the datapath.
module tb_instr_cache_ctrl;
  import instr_cache_pkg::*;

  localparam int TAG_W = 28;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_cache_ctrl_if bus();
  logic              flush_i, flush_ack_o, dp_search_o, dp_new_rvalid_o, dp_new_rdata_o;
  logic              dp_soft_rst_o, dp_miss_i;
  logic              dp_data_ready_i = 1'b0;
  logic [31:0]       dp_addr_o;
  logic [TAG_W-1:0]  dp_tag_o;
  logic [2:0]        dp_rplc_idx_o;

  instr_cache_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus.slave),
    .flush_i         (flush_i),
    .flush_ack_o     (flush_ack_o),
    .dp_search_o     (dp_search_o),
    .dp_addr_o       (dp_addr_o),
    .dp_new_rvalid_o (dp_new_rvalid_o),
    .dp_new_rdata_o  (dp_new_rdata_o),
    .dp_soft_rst_o   (dp_soft_rst_o),
    .dp_tag_o        (dp_tag_o),
    .dp_rplc_idx_o   (dp_rplc_idx_o),
    .dp_miss_i       (dp_miss_i),
    .dp_data_ready_i (dp_data_ready_i)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in: 8 lines of {valid, tag}.
  logic              m_v [8];
  logic [TAG_W-1:0]  m_tag [8];
  logic              model_clr = 1'b0;
  logic              pre_en = 1'b0;
  logic [TAG_W-1:0]  pre_tag = '0;

  always_comb begin
    dp_miss_i = 1'b1;
    for (int i = 0; i < 8; i++)
      if (m_v[i] === 1'b1 && m_tag[i] == dp_addr_o[31:4]) dp_miss_i = 1'b0;
  end

  always @(posedge clk) begin
    dp_data_ready_i <= dp_search_o & ~dp_miss_i;
    if (dp_new_rdata_o) begin
      m_v[dp_rplc_idx_o]   <= 1'b1;
      m_tag[dp_rplc_idx_o] <= dp_tag_o;
    end
    if (dp_soft_rst_o || model_clr)
      for (int i = 0; i < 8; i++) m_v[i] <= 1'b0;
    if (pre_en) begin
      m_v[0]   <= 1'b1;
      m_tag[0] <= pre_tag;
    end
  end

  // Scoreboard queues: rvalid {cyc, new_rdata, new_rvalid, idx, tag},
  // memory grant {cyc, addr}, flush pulse {cyc, ack, soft_rst, gnt}.
  logic [40:0] rv_q[$];
  logic [39:0] mem_q[$];
  logic [10:0] flush_q[$];

  logic [2:0]       ptr_m = 3'd0;
  logic [TAG_W-1:0] last_tag = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=unexpected_output required=none (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    logic [40:0] e_rv;
    logic [39:0] e_mem;
    logic [10:0] e_fl;
    if (bus.instr_rvalid_o === 1'b1) begin
      if (rv_q.size() == 0) unexpected("rvalid");
      else begin
        e_rv = rv_q.pop_front();
        check("rvalid", {cyc[7:0], dp_new_rdata_o, dp_new_rvalid_o, dp_rplc_idx_o, dp_tag_o}, e_rv);
      end
    end
    if (bus.mem_req_o === 1'b1 && bus.mem_gnt_i === 1'b1) begin
      if (mem_q.size() == 0) unexpected("mem_handshake");
      else begin
        e_mem = mem_q.pop_front();
        check("mem_handshake", {cyc[7:0], bus.mem_addr_o}, e_mem);
      end
    end
    if (flush_ack_o === 1'b1 || dp_soft_rst_o === 1'b1) begin
      if (flush_q.size() == 0) unexpected("flush_pulse");
      else begin
        e_fl = flush_q.pop_front();
        check("flush_pulse", {cyc[7:0], flush_ack_o, dp_soft_rst_o, bus.instr_gnt_o}, e_fl);
      end
    end
  end

  function automatic logic [102:0] all_outs();
    return {bus.instr_gnt_o, bus.instr_rvalid_o, bus.mem_req_o, bus.mem_addr_o, flush_ack_o,
            dp_search_o, dp_addr_o, dp_new_rvalid_o, dp_new_rdata_o, dp_soft_rst_o,
            dp_tag_o, dp_rplc_idx_o};
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clr = 1'b1;
    next();
    next();
    rst = 1'b0;
    model_clr = 1'b0;
    ptr_m = 3'd0;
    last_tag = '0;
  endtask

  // Memory side of a miss: gd cycles of ungranted request, grant, then the
  // refill lands rd cycles after the grant; flush_i pulses at wait cycle fa.
  task automatic refill(input logic [31:0] a, input int gd, input int rd, input int fa);
    for (int i = 0; i < gd; i++) begin
      @(negedge clk);
      check("mem_req_hold", {bus.mem_req_o, bus.mem_addr_o}, {1'b1, a & 32'hFFFF_FFF0});
      next();
    end
    bus.mem_gnt_i = 1'b1;
    mem_q.push_back({8'(cyc), a & 32'hFFFF_FFF0});
    next();
    bus.mem_gnt_i = 1'b0;
    for (int i = 0; i < rd - 1; i++) begin
      if (i == fa) flush_i = 1'b1;
      next();
      flush_i = 1'b0;
    end
    bus.mem_rvalid_i = 1'b1;
    rv_q.push_back({8'(cyc), 1'b1, 1'b1, ptr_m, a[31:4]});
    if (fa >= 0) flush_q.push_back({8'(cyc + 1), 1'b1, 1'b1, 1'b0});
    next();
    bus.mem_rvalid_i = 1'b0;
    ptr_m = ptr_m + 3'd1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic hit, input int gd, input int rd, input int fa);
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = a;
    @(negedge clk);
    check("gnt", {bus.instr_gnt_o, dp_search_o, dp_addr_o}, {1'b1, 1'b1, a});
    if (hit) rv_q.push_back({8'(cyc + 1), 1'b0, 1'b0, ptr_m, last_tag});
    else last_tag = a[31:4];
    next();
    bus.instr_req_i = 1'b0;
    if (!hit) refill(a, gd, rd, fa);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_req_i  = 1'b0;
    bus.instr_addr_i = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    flush_i          = 1'b0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("reset_outputs", all_outs(), '0);
    check("reset_state", dut.state_q, IDLE);
    check("reset_counters", {dut.hit_cnt, dut.miss_cnt, dut.flush_pend_q}, '0);

    // Hit path on a preloaded line
    next();
    pre_tag = 28'h000_0100;
    pre_en = 1'b1;
    next();
    pre_en = 1'b0;
    fetch(32'h0000_1004, 1'b1, 0, 0, -1);
    @(negedge clk);
    check("hit_no_mem_req", bus.mem_req_o, 1'b0);
    check("hit_cnt_1", dut.hit_cnt, 32'd1);
    next();

    // Cold miss with delayed grant and refill
    fetch(32'h0000_2008, 1'b0, 3, 2, -1);
    @(negedge clk);
    check("ptr_after_refill", dp_rplc_idx_o, 3'd1);
    check("miss_cnt_1", dut.miss_cnt, 32'd1);
    check("state_idle_after_refill", dut.state_q, IDLE);
    next();

    // Pointer wrap over nine distinct blocks
    do_reset();
    for (int i = 0; i < 9; i++) fetch(32'h0001_0000 + 32'(i * 16), 1'b0, 0, 1, -1);
    @(negedge clk);
    check("ptr_wrapped", dp_rplc_idx_o, 3'd1);
    check("miss_cnt_9", dut.miss_cnt, 32'd9);
    next();
    fetch(32'h0001_0010, 1'b1, 0, 0, -1);
    @(negedge clk);
    check("hit_after_wrap", dut.hit_cnt, 32'd1);
    next();

    // Flush raised while waiting for refill data
    fetch(32'h0003_0000, 1'b0, 1, 3, 0);
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h0001_0010;
    @(negedge clk);
    check("no_gnt_in_flush", bus.instr_gnt_o, 1'b0);
    next();
    fetch(32'h0001_0010, 1'b0, 0, 1, -1);

    // Flush coincident with a request in IDLE
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h0004_0000;
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_beats_req", bus.instr_gnt_o, 1'b0);
    flush_q.push_back({8'(cyc + 1), 1'b1, 1'b1, 1'b0});
    next();
    flush_i = 1'b0;
    @(negedge clk);
    check("no_gnt_during_flush", bus.instr_gnt_o, 1'b0);
    next();
    fetch(32'h0004_0000, 1'b0, 0, 1, -1);

    // Asynchronous reset while a miss request is pending
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h0005_0000;
    @(negedge clk);
    check("gnt_before_reset", bus.instr_gnt_o, 1'b1);
    next();
    bus.instr_req_i  = 1'b0;
    bus.instr_addr_i = '0;
    @(negedge clk);
    check("mem_req_before_reset", bus.mem_req_o, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", all_outs(), '0);
    check("async_reset_state", dut.state_q, IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ptr_m = 3'd0;
    last_tag = '0;
    bus.mem_gnt_i    = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    @(negedge clk);
    check("late_rvalid_ignored", {dp_new_rdata_o, dp_new_rvalid_o, bus.instr_rvalid_o, bus.mem_req_o}, 4'b0);
    next();
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    @(negedge clk);
    check("idle_after_stray", dut.state_q, IDLE);
    next();

    check("rv_q_drained", rv_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);
    check("flush_q_drained", flush_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_cache_ctrl.md
Name: instr_cache_ctrl

Overview:
- Control FSM that sequences the L0 instruction-cache datapath.
- Accepts core fetch requests and drives datapath search. On a miss it issues a single-beat block refill to memory, then returns the refilled word to the core.
- Owns the round-robin replacement pointer, the soft-flush sequence and hit/miss performance counters.
- Sits between the RISC-V fetch stage, the cache datapath and the instruction memory port.

Parameters:
- LOG2_NUM_BLKS, 3, log2 of cache line count; drives replacement pointer width.
- RAM_WIDTH, 128, memory block width in bits; TAG_W = 30 - log2(RAM_WIDTH/32).
- CNT_W, 32, width of the hit/miss performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- instr_req_i  in  1  core fetch request
- instr_addr_i  in  32  core fetch byte address
- instr_gnt_o  out  1  request accepted this cycle
- instr_rvalid_o  out  1  datapath data output valid for the core
- flush_i  in  1  single-cycle flush (invalidate-all) request
- flush_ack_o  out  1  single-cycle pulse when the flush has been applied
- dp_search_o  out  1  datapath search strobe
- dp_addr_o  out  32  address presented to the datapath
- dp_new_rvalid_o  out  1  datapath output-select strobe (refill bypass)
- dp_new_rdata_o  out  1  datapath refill write strobe
- dp_soft_rst_o  out  1  datapath invalidate-all strobe
- dp_tag_o  out  TAG_W  tag of the block being refilled
- dp_rplc_idx_o  out  LOG2_NUM_BLKS  replacement line index
- dp_miss_i  in  1  combinational miss, same cycle as dp_search_o
- dp_data_ready_i  in  1  registered hit indication, one cycle after search
- mem_req_o  out  1  memory block read request
- mem_addr_o  out  32  block-aligned address: {tag, zeros}
- mem_gnt_i  in  1  memory accepted the request
- mem_rvalid_i  in  1  refill data valid on the datapath data bus

Behaviour:
- Reset: state IDLE; every output 0; replacement pointer 0; counters 0; flush_pend 0; latched address 0.
- States: IDLE, MISS_REQ, MISS_WAIT, FLUSH.
- IDLE:
  - instr_gnt_o = instr_req_i & ~flush_i & ~flush_pend.
  - dp_search_o = instr_gnt_o.
  - dp_addr_o = instr_addr_i; the address is latched on grant.
- Hit: granted & ~dp_miss_i. Stay in IDLE; instr_rvalid_o = dp_data_ready_i on the next cycle (latency 1). Back-to-back requests are allowed; hit_cnt increments.
- Miss: granted & dp_miss_i. Latch tag = instr_addr_i[31:32-TAG_W]; go to MISS_REQ; miss_cnt increments.
- MISS_REQ:
  - mem_req_o = 1; mem_addr_o holds the latched tag with low bits zero; dp_addr_o = latched address.
  - mem_gnt_i -> MISS_WAIT. mem_req_o stays high until granted.
- MISS_WAIT: wait for mem_rvalid_i. In that cycle:
  - dp_new_rdata_o = dp_new_rvalid_o = instr_rvalid_o = 1.
  - dp_tag_o = latched tag; dp_rplc_idx_o = pointer.
  - Next cycle: pointer increments (wraps 2^LOG2_NUM_BLKS-1 -> 0); state -> FLUSH if flush_pend, else IDLE.
- dp_tag_o and dp_rplc_idx_o are driven continuously from the latched tag and pointer.
- Flush:
  - flush_i in IDLE, or coincident with instr_req_i: flush wins, no grant, go to FLUSH.
  - flush_i in MISS_REQ or MISS_WAIT: set flush_pend; it is serviced after the refill completes.
  - FLUSH: dp_soft_rst_o = 1 and flush_ack_o = 1 for one cycle; clear flush_pend; go to IDLE.
  - The pointer is not reset by a flush.
- Stray inputs: mem_rvalid_i outside MISS_WAIT and mem_gnt_i outside MISS_REQ are ignored.
- Reset mid-miss: return to IDLE immediately; any late memory response is ignored.
- Counters: hit_cnt and miss_cnt saturate at all-ones, are cleared only by rst and are exposed internally for debug taps.
- Only one miss is outstanding at a time; no request is granted outside IDLE.

Decomposition:
- Shared package instr_cache_pkg holds:
  - the state enum, ic_state_e;
  - the TAG_W and WORDS_IN_BLOCK derivation functions;
  - the block address builder function.
- One sub-module: instr_cache_rr_ptr, a round-robin pointer with an increment enable and wrap, reused later for the data cache.

Test Plan:
- Hit path: preload line 0 with tag 0x0000100 (RAM_WIDTH=128), request 0x00001004 -> gnt same cycle, instr_rvalid_o on the next cycle, no mem_req_o, hit_cnt=1.
- Miss/refill: request 0x00002008 on a cold cache; delay mem_gnt_i by 3 cycles; mem_rvalid_i 2 cycles later.
  - Before grant: mem_req_o held 3 cycles with mem_addr_o=0x00002000.
  - Refill cycle: dp_new_rdata_o, dp_new_rvalid_o and instr_rvalid_o all 1 in the same cycle; dp_rplc_idx_o=0.
  - Afterwards: pointer=1.
- Pointer wrap: 9 consecutive misses to distinct blocks -> rplc indices 0..7 then 0.
- Flush during miss: flush_i in MISS_WAIT -> refill completes, then dp_soft_rst_o and flush_ack_o high one cycle later; the next request is not granted during FLUSH.
- Simultaneous flush_i and instr_req_i in IDLE -> instr_gnt_o=0 and dp_soft_rst_o=1 next cycle; the request is granted the cycle after.
- Reset asserted in MISS_REQ -> all outputs 0 asynchronously; a subsequent mem_rvalid_i produces no dp_new_rdata_o.
